// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Word-load encoding from the shared funct3 constants; fetches always use it.
    localparam logic [2:0] FUNCT3_LW = 3'b010;

    // New requests can only be taken when the port is idle or finishing a response.
    function automatic logic can_accept(input state_e s);
        return (s == IDLE) || (s == RESP);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters with an anti-starvation counter.
// Data normally wins a conflict; after STARVE_MAX data grants in a row with fetch
// waiting, fetch is forced through.
import mem_arb_pkg::*;

module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic f_valid_i,
    input  logic d_valid_i,
    output logic f_grant_o,
    output logic d_grant_o
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          force_f_s;

    // Grant decision: data wins ties unless fetch has waited long enough.
    always_comb begin
        force_f_s = (starve_q == STARVE_LIM);
        f_grant_o = en_i && f_valid_i && (!d_valid_i || force_f_s);
        d_grant_o = en_i && d_valid_i && !(f_valid_i && force_f_s);
    end

    // Starve counter next value: clear on fetch grant, count data grants while fetch waits.
    always_comb begin
        starve_d = starve_q;
        if (f_grant_o) begin
            starve_d = '0;
        end else if (d_grant_o && f_valid_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction in flight: accept -> ISSUE (one enable cycle) -> optional WAIT
// -> RESP (one-cycle response pulse to the owner, next request may be accepted).
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid_i,
    input  logic [AWIDTH-1:0] f_req_addr_i,
    output logic              f_req_ready_o,
    output logic              f_rsp_valid_o,
    output logic [DWIDTH-1:0] f_rsp_data_o,
    input  logic              d_req_valid_i,
    input  logic [AWIDTH-1:0] d_req_addr_i,
    input  logic [DWIDTH-1:0] d_req_wdata_i,
    input  logic              d_req_we_i,
    input  logic [2:0]        d_req_funct3_i,
    output logic              d_req_ready_o,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rsp_data_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic              busy_o
);

    // With a registered memory the read word arrives in the RESP cycle itself and is
    // forwarded live; a combinational memory is sampled at the end of ISSUE instead.
    localparam bit       LIVE_RSP  = (LATENCY != 0);
    localparam bit       LONG_LAT  = (LATENCY > 1);
    localparam logic [7:0] WAIT_LAST = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [7:0]        wait_cnt_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [2:0]        mem_f3_q;
    logic              f_rsp_valid_q;
    logic              d_rsp_valid_q;
    logic [DWIDTH-1:0] f_data_q;
    logic [DWIDTH-1:0] d_data_q;

    logic win_en_s;
    logic f_acc_s;
    logic d_acc_s;
    logic cap_en_s;
    logic live_s;

    // Stores answer with zero data; loads return the memory word.
    function automatic logic [DWIDTH-1:0] rsp_word(input logic we, input logic [DWIDTH-1:0] d);
        return we ? {DWIDTH{1'b0}} : d;
    endfunction

    // Ready window: only in IDLE/RESP and never while reset is asserted.
    always_comb begin
        win_en_s = rst && can_accept(state_q);
    end

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .en_i      (win_en_s),
        .f_valid_i (f_req_valid_i),
        .d_valid_i (d_req_valid_i),
        .f_grant_o (f_acc_s),
        .d_grant_o (d_acc_s)
    );

    // Capture strobe and live-forward select for response data.
    always_comb begin
        cap_en_s = 1'b0;
        live_s   = 1'b0;
        if (LIVE_RSP) begin
            cap_en_s = (state_q == RESP);
            live_s   = (state_q == RESP);
        end else begin
            cap_en_s = (state_q == ISSUE);
            live_s   = 1'b0;
        end
    end

    // Transaction FSM with registered memory controls and response pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_F;
            we_q          <= 1'b0;
            wait_cnt_q    <= 8'd0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_f3_q      <= 3'b000;
            f_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
        end else begin
            f_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (f_acc_s) begin
                        state_q     <= ISSUE;
                        owner_q     <= OWN_F;
                        we_q        <= 1'b0;
                        mem_addr_q  <= f_req_addr_i;
                        mem_wdata_q <= '0;
                        mem_re_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_f3_q    <= FUNCT3_LW;
                    end else if (d_acc_s) begin
                        state_q     <= ISSUE;
                        owner_q     <= OWN_D;
                        we_q        <= d_req_we_i;
                        mem_addr_q  <= d_req_addr_i;
                        mem_wdata_q <= d_req_wdata_i;
                        mem_re_q    <= !d_req_we_i;
                        mem_we_q    <= d_req_we_i;
                        mem_f3_q    <= d_req_funct3_i;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_f3_q    <= 3'b000;
                    if (LONG_LAT) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= 8'd0;
                    end else begin
                        state_q       <= RESP;
                        f_rsp_valid_q <= (owner_q == OWN_F);
                        d_rsp_valid_q <= (owner_q == OWN_D);
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= RESP;
                        f_rsp_valid_q <= (owner_q == OWN_F);
                        d_rsp_valid_q <= (owner_q == OWN_D);
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response data capture for the owner; held until its next capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_data_q <= '0;
            d_data_q <= '0;
        end else if (cap_en_s) begin
            if (owner_q == OWN_F) begin
                f_data_q <= mem_data_i;
            end else begin
                d_data_q <= rsp_word(we_q, mem_data_i);
            end
        end
    end

    // Output drive: registered controls, live forward of memory data in RESP when needed.
    always_comb begin
        f_req_ready_o  = f_acc_s;
        d_req_ready_o  = d_acc_s;
        f_rsp_valid_o  = f_rsp_valid_q;
        d_rsp_valid_o  = d_rsp_valid_q;
        mem_addr_o     = mem_addr_q;
        mem_data_o     = mem_wdata_q;
        mem_read_en_o  = mem_re_q;
        mem_write_en_o = mem_we_q;
        mem_funct3_o   = mem_f3_q;
        busy_o         = (state_q != IDLE);
        f_rsp_data_o   = f_data_q;
        d_rsp_data_o   = d_data_q;
        if (live_s && (owner_q == OWN_F)) begin
            f_rsp_data_o = mem_data_i;
        end else if (live_s && (owner_q == OWN_D)) begin
            d_rsp_data_o = rsp_word(we_q, mem_data_i);
        end else begin
            f_rsp_data_o = f_data_q;
            d_rsp_data_o = d_data_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LATENCY 1, 3, 0), each with its own
// small word memory model; per-cycle vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic mem_clr;

    logic        rst_a    [3];
    logic        f_valid  [3];
    logic [31:0] f_addr   [3];
    logic        f_ready  [3];
    logic        f_rsp    [3];
    logic [31:0] f_rdata  [3];
    logic        d_valid  [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic        d_we     [3];
    logic [2:0]  d_f3     [3];
    logic        d_ready  [3];
    logic        d_rsp    [3];
    logic [31:0] d_rdata  [3];
    logic [31:0] m_addr   [3];
    logic [31:0] m_wdata  [3];
    logic        m_re     [3];
    logic        m_we     [3];
    logic [2:0]  m_f3     [3];
    logic [31:0] m_rdata  [3];
    logic        busy     [3];

    int checks;
    int errors;

    // Contents of any memory word that has not been written.
    function automatic logic [31:0] init_word(input logic [5:0] i);
        return 32'h0000_0013 + ({26'd0, i} << 12);
    endfunction

    function automatic logic [31:0] faddr(input int idx);
        return 32'h0100_0000 + 32'(idx * 4);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        logic [31:0] mem  [64];
        logic [63:0] wv;
        logic [31:0] pipe [4];
        logic [5:0]  ridx;
        logic [31:0] rword;

        assign ridx  = m_addr[g][7:2];
        assign rword = wv[ridx] ? mem[ridx] : init_word(ridx);

        always @(posedge clk) begin
            if (mem_clr) begin
                wv <= '0;
            end else if (m_we[g]) begin
                wv[ridx]  <= 1'b1;
                mem[ridx] <= m_wdata[g];
            end
            pipe[0] <= rword;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end

        if (LAT == 0) begin : g_comb
            assign m_rdata[g] = rword;
        end else begin : g_pipe
            assign m_rdata[g] = pipe[LAT-1];
        end

        mem_port_arbiter #(
            .AWIDTH     (32),
            .DWIDTH     (32),
            .LATENCY    (LAT),
            .STARVE_MAX (4)
        ) dut (
            .clk            (clk),
            .rst            (rst_a[g]),
            .f_req_valid_i  (f_valid[g]),
            .f_req_addr_i   (f_addr[g]),
            .f_req_ready_o  (f_ready[g]),
            .f_rsp_valid_o  (f_rsp[g]),
            .f_rsp_data_o   (f_rdata[g]),
            .d_req_valid_i  (d_valid[g]),
            .d_req_addr_i   (d_addr[g]),
            .d_req_wdata_i  (d_wdata[g]),
            .d_req_we_i     (d_we[g]),
            .d_req_funct3_i (d_f3[g]),
            .d_req_ready_o  (d_ready[g]),
            .d_rsp_valid_o  (d_rsp[g]),
            .d_rsp_data_o   (d_rdata[g]),
            .mem_addr_o     (m_addr[g]),
            .mem_data_o     (m_wdata[g]),
            .mem_read_en_o  (m_re[g]),
            .mem_write_en_o (m_we[g]),
            .mem_funct3_o   (m_f3[g]),
            .mem_data_i     (m_rdata[g]),
            .busy_o         (busy[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] fa;
        logic        dv;
        logic [31:0] da;
        logic        dwe;
        logic [31:0] dwd;
        logic [2:0]  df3;
        logic        fr;
        logic        dr;
        logic        re;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [2:0]  mf3;
        logic        fvo;
        logic [31:0] fdo;
        logic        dvo;
        logic [31:0] ddo;
        logic        busy;
    } vec_t;

    vec_t vec [18];

    // Fetch-only stream on one instance: checks data, first latency and pulse spacing.
    task automatic stream(input int inst, input int n, input int base, input int gap);
        int   sent;
        int   got;
        int   cyc;
        int   acc0;
        int   last;
        logic acc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        acc0 = 0;
        last = 0;
        @(posedge clk); #1;
        f_valid[inst] = 1'b1;
        f_addr[inst]  = faddr(base);
        while ((got < n) && (cyc < 80)) begin
            @(negedge clk);
            acc = f_valid[inst] & f_ready[inst];
            if (acc && (sent == 0)) acc0 = cyc;
            if (f_rsp[inst]) begin
                chk($sformatf("i%0d_stream_data%0d", inst, got), f_rdata[inst], init_word(6'(base + got)));
                chk($sformatf("i%0d_stream_dquiet", inst), 32'(d_rsp[inst]), 32'd0);
                if (got == 0) chk($sformatf("i%0d_stream_latency", inst), 32'(cyc - acc0), 32'(gap));
                else          chk($sformatf("i%0d_stream_gap", inst), 32'(cyc - last), 32'(gap));
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < n) f_addr[inst] = faddr(base + sent);
                else          f_valid[inst] = 1'b0;
            end
            cyc++;
        end
        f_valid[inst] = 1'b0;
        chk($sformatf("i%0d_stream_done", inst), 32'(got), 32'(n));
    endtask

    initial begin
        int gcount;
        int gcyc;
        checks  = 0;
        errors  = 0;
        mem_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rst_a[i]   = 1'b0;
            f_valid[i] = 1'b0;
            f_addr[i]  = 32'd0;
            d_valid[i] = 1'b0;
            d_addr[i]  = 32'd0;
            d_wdata[i] = 32'd0;
            d_we[i]    = 1'b0;
            d_f3[i]    = 3'b000;
        end

        //          rst   fv    fa            dv    da            dwe   dwd            df3     | fr   dr   re   we   maddr         mdata          mf3     fvo  fdo            dvo  ddo            busy
        vec[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vec[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vec[2]  = '{1'b1, 1'b1, 32'h0100_0000,1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vec[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b1,1'b0,32'h0100_0000,32'h0,         3'b010, 1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vec[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b1,32'h13,       1'b0,32'h0,        1'b1};
        vec[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h13,       1'b0,32'h0,        1'b0};
        vec[6]  = '{1'b1, 1'b1, 32'h0100_0004,1'b1, 32'h0200_0000,1'b0, 32'h0,         3'b100,   1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h13,       1'b0,32'h0,        1'b0};
        vec[7]  = '{1'b1, 1'b1, 32'h0100_0004,1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b1,1'b0,32'h0200_0000,32'h0,         3'b100, 1'b0,32'h13,       1'b0,32'h0,        1'b1};
        vec[8]  = '{1'b1, 1'b1, 32'h0100_0004,1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h13,       1'b1,32'h13,       1'b1};
        vec[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b1,1'b0,32'h0100_0004,32'h0,         3'b010, 1'b0,32'h13,       1'b0,32'h13,       1'b1};
        vec[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b1,32'h1013,     1'b0,32'h13,       1'b1};
        vec[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h1013,     1'b0,32'h13,       1'b0};
        vec[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0200_0010,1'b1, 32'hDEAD_BEEF, 3'b010,   1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h1013,     1'b0,32'h13,       1'b0};
        vec[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b1,32'h0200_0010,32'hDEAD_BEEF, 3'b010, 1'b0,32'h1013,     1'b0,32'h13,       1'b1};
        vec[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0200_0010,1'b0, 32'h0,         3'b010,   1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h1013,     1'b1,32'h0,        1'b1};
        vec[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b1,1'b0,32'h0200_0010,32'h0,         3'b010, 1'b0,32'h1013,     1'b0,32'h0,        1'b1};
        vec[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h1013,     1'b1,32'hDEAD_BEEF,1'b1};
        vec[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         3'b000,   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         3'b000, 1'b0,32'h1013,     1'b0,32'hDEAD_BEEF,1'b0};

        @(posedge clk); #1;
        mem_clr  = 1'b0;
        rst_a[1] = 1'b1;
        rst_a[2] = 1'b1;

        // Per-cycle vectors on the LATENCY=1 instance: reset, fetch, conflict, store/load.
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            rst_a[0]   = vec[k].rst;
            f_valid[0] = vec[k].fv;
            f_addr[0]  = vec[k].fa;
            d_valid[0] = vec[k].dv;
            d_addr[0]  = vec[k].da;
            d_we[0]    = vec[k].dwe;
            d_wdata[0] = vec[k].dwd;
            d_f3[0]    = vec[k].df3;
            @(negedge clk);
            chk($sformatf("v%0d_f_ready", k),  32'(f_ready[0]), 32'(vec[k].fr));
            chk($sformatf("v%0d_d_ready", k),  32'(d_ready[0]), 32'(vec[k].dr));
            chk($sformatf("v%0d_read_en", k),  32'(m_re[0]),    32'(vec[k].re));
            chk($sformatf("v%0d_write_en", k), 32'(m_we[0]),    32'(vec[k].we));
            chk($sformatf("v%0d_mem_addr", k), m_addr[0],       vec[k].maddr);
            chk($sformatf("v%0d_mem_data", k), m_wdata[0],      vec[k].mdata);
            chk($sformatf("v%0d_funct3", k),   32'(m_f3[0]),    32'(vec[k].mf3));
            chk($sformatf("v%0d_f_rsp", k),    32'(f_rsp[0]),   32'(vec[k].fvo));
            chk($sformatf("v%0d_f_data", k),   f_rdata[0],      vec[k].fdo);
            chk($sformatf("v%0d_d_rsp", k),    32'(d_rsp[0]),   32'(vec[k].dvo));
            chk($sformatf("v%0d_d_data", k),   d_rdata[0],      vec[k].ddo);
            chk($sformatf("v%0d_busy", k),     32'(busy[0]),    32'(vec[k].busy));
        end

        // Starvation: both requesters always valid, grants must go D,D,D,D,F repeating.
        @(posedge clk); #1;
        f_valid[0] = 1'b1;
        f_addr[0]  = faddr(10);
        d_valid[0] = 1'b1;
        d_addr[0]  = 32'h0200_002C;
        d_we[0]    = 1'b0;
        d_f3[0]    = 3'b010;
        gcount = 0;
        gcyc   = 0;
        while ((gcount < 10) && (gcyc < 60)) begin
            @(negedge clk);
            if (f_ready[0] || d_ready[0]) begin
                chk($sformatf("grant%0d_excl", gcount), 32'(f_ready[0] & d_ready[0]), 32'd0);
                chk($sformatf("grant%0d_is_f", gcount), 32'(f_ready[0]), 32'((gcount % 5) == 4));
                gcount++;
            end
            @(posedge clk); #1;
            gcyc++;
        end
        f_valid[0] = 1'b0;
        d_valid[0] = 1'b0;
        chk("starve_grants", 32'(gcount), 32'd10);
        repeat (5) @(posedge clk);

        // Reset in the WAIT cycle of a LATENCY=3 fetch drops the transaction.
        @(posedge clk); #1;
        f_valid[1] = 1'b1;
        f_addr[1]  = faddr(8);
        @(negedge clk);
        chk("rw_accept", 32'(f_ready[1]), 32'd1);
        @(posedge clk); #1;
        f_valid[1] = 1'b0;
        @(negedge clk);
        chk("rw_issue_re", 32'(m_re[1]), 32'd1);
        @(posedge clk); #1;
        rst_a[1] = 1'b0;
        @(negedge clk);
        chk("rw_wait_busy", 32'(busy[1]), 32'd1);
        @(posedge clk); #1;
        rst_a[1] = 1'b1;
        @(negedge clk);
        chk("rw_busy_after", 32'(busy[1]), 32'd0);
        chk("rw_re_after", 32'(m_re[1]), 32'd0);
        chk("rw_we_after", 32'(m_we[1]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rw_no_rsp%0d", k), 32'(f_rsp[1]), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        stream(1, 1, 9, 4);

        // Back-to-back fetch streams: spacing 2 for LATENCY 0/1, 4 for LATENCY 3.
        stream(2, 4, 12, 2);
        stream(1, 4, 16, 4);
        stream(0, 3, 20, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
